// File: rtl/picosoc_gpio.sv
// Memory-mapped GPIO block for PicoSoC: output/enable registers, synchronised
// inputs, and per-pin edge-detect interrupts with byte-strobed W1C status.
module picosoc_gpio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    output logic             ready,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [7:0] OFF_OUT     = 8'h00;
    localparam logic [7:0] OFF_OE      = 8'h04;
    localparam logic [7:0] OFF_IN      = 8'h08;
    localparam logic [7:0] OFF_SET     = 8'h0C;
    localparam logic [7:0] OFF_CLR     = 8'h10;
    localparam logic [7:0] OFF_TGL     = 8'h14;
    localparam logic [7:0] OFF_RISE_EN = 8'h18;
    localparam logic [7:0] OFF_FALL_EN = 8'h1C;
    localparam logic [7:0] OFF_STATUS  = 8'h20;

    logic [WIDTH-1:0]             r_out;
    logic [WIDTH-1:0]             r_oe;
    logic [WIDTH-1:0]             r_rise_en;
    logic [WIDTH-1:0]             r_fall_en;
    logic [WIDTH-1:0]             r_status;
    logic [WIDTH-1:0]             r_prev;
    logic [SYNC_STAGES*WIDTH-1:0] r_sync;
    logic                         r_ready;
    logic [31:0]                  r_rdata;

    logic                         w_hit;
    logic                         w_acc;
    logic                         w_wr;
    logic [7:0]                   w_off;
    logic [31:0]                  w_bmask;
    logic [31:0]                  w_rd_val;
    logic [WIDTH-1:0]             w_mask;
    logic [WIDTH-1:0]             w_d;
    logic [WIDTH-1:0]             w_s;
    logic [WIDTH-1:0]             w_evt;
    logic [WIDTH-1:0]             w_w1c;
    logic [WIDTH-1:0]             w_out_nxt;
    logic                         w_unused;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        return 32'(v);
    endfunction

    assign w_bmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign w_mask   = w_bmask[WIDTH-1:0];
    assign w_d      = wdata[WIDTH-1:0] & w_mask;
    assign w_off    = addr[7:0];
    assign w_hit    = (addr[31:8] == BASE_ADDR[31:8]);
    // ready doubles as the busy flag, so a held request is taken once every other cycle
    assign w_acc    = valid && w_hit && !r_ready;
    assign w_wr     = w_acc && (wstrb != 4'b0000);
    assign w_s      = r_sync[SYNC_STAGES*WIDTH-1 -: WIDTH];
    assign w_evt    = (w_s & ~r_prev & r_rise_en) | (~w_s & r_prev & r_fall_en);
    assign w_unused = ^{wdata, w_bmask};

    assign ready    = r_ready;
    assign rdata    = r_rdata;
    assign gpio_out = r_out;
    assign gpio_oe  = r_oe;
    assign irq      = |r_status;

    // Read multiplexer: write-only and unmapped offsets read as zero.
    always_comb begin
        w_rd_val = 32'h0000_0000;
        case (w_off)
            OFF_OUT:     w_rd_val = zext(r_out);
            OFF_OE:      w_rd_val = zext(r_oe);
            OFF_IN:      w_rd_val = zext(w_s);
            OFF_RISE_EN: w_rd_val = zext(r_rise_en);
            OFF_FALL_EN: w_rd_val = zext(r_fall_en);
            OFF_STATUS:  w_rd_val = zext(r_status);
            default:     w_rd_val = 32'h0000_0000;
        endcase
    end

    // Next OUT value and the W1C clear mask for the current write.
    always_comb begin
        w_out_nxt = r_out;
        w_w1c     = {WIDTH{1'b0}};
        if (w_wr) begin
            case (w_off)
                OFF_OUT:    w_out_nxt = (r_out & ~w_mask) | w_d;
                OFF_SET:    w_out_nxt = r_out | w_d;
                OFF_CLR:    w_out_nxt = r_out & ~w_d;
                OFF_TGL:    w_out_nxt = r_out ^ w_d;
                OFF_STATUS: w_w1c     = w_d;
                default:    w_out_nxt = r_out;
            endcase
        end else begin
            w_out_nxt = r_out;
        end
    end

    // Bus-visible registers and handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready   <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_out     <= {WIDTH{1'b0}};
            r_oe      <= {WIDTH{1'b0}};
            r_rise_en <= {WIDTH{1'b0}};
            r_fall_en <= {WIDTH{1'b0}};
            r_status  <= {WIDTH{1'b0}};
        end else begin
            r_ready  <= w_acc;
            r_rdata  <= w_acc ? w_rd_val : 32'h0000_0000;
            r_out    <= w_out_nxt;
            // a new event outranks a simultaneous W1C of the same bit
            r_status <= (r_status & ~w_w1c) | w_evt;
            if (w_wr && (w_off == OFF_OE)) begin
                r_oe <= (r_oe & ~w_mask) | w_d;
            end
            if (w_wr && (w_off == OFF_RISE_EN)) begin
                r_rise_en <= (r_rise_en & ~w_mask) | w_d;
            end
            if (w_wr && (w_off == OFF_FALL_EN)) begin
                r_fall_en <= (r_fall_en & ~w_mask) | w_d;
            end
        end
    end

    // Input synchroniser chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync <= {(SYNC_STAGES*WIDTH){1'b0}};
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_sync <= {r_sync[(SYNC_STAGES-1)*WIDTH-1:0], gpio_in};
            r_prev <= w_s;
        end
    end
endmodule

// File: tb/tb_picosoc_gpio.sv
// Randomised self-checking bench for picosoc_gpio against a register-level
// reference model driven one clock at a time.
`timescale 1ns/1ps
module tb_picosoc_gpio;
    localparam int          W    = 16;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_OUT = BASE + 32'h00, A_OE = BASE + 32'h04, A_IN = BASE + 32'h08;
    localparam logic [31:0] A_SET = BASE + 32'h0C, A_CLR = BASE + 32'h10, A_TGL = BASE + 32'h14;
    localparam logic [31:0] A_REN = BASE + 32'h18, A_FEN = BASE + 32'h1C, A_STS = BASE + 32'h20;

    logic clk = 1'b0;
    logic resetn, valid, ready, irq;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] wstrb;
    logic [W-1:0] gpio_in, gpio_out, gpio_oe;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_status;
    logic         m_ready = 1'b0;
    logic [31:0]  m_rdata = 32'h0;
    logic [W-1:0] m_pins[$];

    picosoc_gpio #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = s[i/8];
        return m;
    endfunction

    // One clock edge; the model applies the register-map rules to the inputs seen at that edge.
    task automatic step();
        logic [W-1:0] s, p, ev, d, mk, w1c;
        logic acc;
        logic [31:0] rv;
        @(posedge clk);
        if (!resetn) begin
            m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_status = '0;
            m_ready = 1'b0; m_rdata = 32'h0;
            m_pins = {};
            for (int k = 0; k <= S; k++) m_pins.push_back('0);
        end else begin
            s   = m_pins[S-1];
            p   = m_pins[S];
            ev  = (s & ~p & m_rise) | (~s & p & m_fall);
            acc = valid && (addr[31:8] == BASE[31:8]) && !m_ready;
            mk  = W'(bytemask(wstrb));
            d   = W'(wdata) & mk;
            w1c = '0;
            rv  = 32'h0;
            if (acc) begin
                case (addr[7:0])
                    8'h00: rv = 32'(m_out);
                    8'h04: rv = 32'(m_oe);
                    8'h08: rv = 32'(s);
                    8'h18: rv = 32'(m_rise);
                    8'h1C: rv = 32'(m_fall);
                    8'h20: rv = 32'(m_status);
                    default: rv = 32'h0;
                endcase
                if (wstrb != 4'b0000) begin
                    case (addr[7:0])
                        8'h00: m_out  = (m_out & ~mk) | d;
                        8'h04: m_oe   = (m_oe & ~mk) | d;
                        8'h0C: m_out  = m_out | d;
                        8'h10: m_out  = m_out & ~d;
                        8'h14: m_out  = m_out ^ d;
                        8'h18: m_rise = (m_rise & ~mk) | d;
                        8'h1C: m_fall = (m_fall & ~mk) | d;
                        8'h20: w1c    = d;
                        default: ;
                    endcase
                end
            end
            m_status = (m_status & ~w1c) | ev;
            m_ready  = acc;
            m_rdata  = rv;
            m_pins.push_front(gpio_in);
            void'(m_pins.pop_back());
        end
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_ready) step();
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        step();
        valid = 1'b0; wstrb = 4'b0000;
    endtask

    task automatic test_reset();
        resetn = 1'b0; gpio_in = W'($urandom);
        step(); step();
        checks++;
        if ({ready, rdata, gpio_out, gpio_oe, irq} !== {1'b0, 32'h0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b %h %h %h %b, want all zero", ready, rdata, gpio_out, gpio_oe, irq);
        end
        resetn = 1'b1; gpio_in = 16'hFFFF;
        repeat (5) step();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_pins_high_irq: got %b want 0", irq); end
        bus(A_IN, 32'h0, 4'h0);
        checks++;
        if (rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL in_read: got %h want 0000ffff", rdata); end
    endtask

    task automatic test_basic();
        bus(A_OUT, 32'h0000_00A5, 4'hF);
        bus(A_OE, 32'h0000_00FF, 4'hF);
        checks++;
        if (gpio_out !== 16'h00A5 || gpio_oe !== 16'h00FF) begin
            errors++; $display("FAIL basic_pins: got out=%h oe=%h want 00a5 00ff", gpio_out, gpio_oe);
        end
        bus(A_OUT, 32'h0, 4'h0);
        checks++;
        if (ready !== 1'b1 || rdata !== 32'h0000_00A5) begin
            errors++; $display("FAIL basic_read: got ready=%b rdata=%h want 1 000000a5", ready, rdata);
        end
    endtask

    task automatic test_set_clr_tgl();
        bus(A_SET, 32'h0A, 4'hF);
        checks++;
        if (gpio_out !== 16'h00AF) begin errors++; $display("FAIL set: got %h want 00af", gpio_out); end
        bus(A_CLR, 32'h81, 4'hF);
        checks++;
        if (gpio_out !== 16'h002E) begin errors++; $display("FAIL clr: got %h want 002e", gpio_out); end
        bus(A_TGL, 32'hFF, 4'hF);
        checks++;
        if (gpio_out !== 16'h00D1) begin errors++; $display("FAIL tgl: got %h want 00d1", gpio_out); end
        bus(A_SET, 32'h0, 4'h0);
        checks++;
        if (ready !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL wo_read: got ready=%b rdata=%h want 1 0", ready, rdata);
        end
    endtask

    task automatic test_strobe();
        bus(A_OUT, 32'h0, 4'hF);
        bus(A_SET, 32'hFFFF_FFFF, 4'b0010);
        checks++;
        if (gpio_out !== 16'hFF00) begin errors++; $display("FAIL strobe_set: got %h want ff00", gpio_out); end
        bus(A_OUT, 32'h0, 4'h0);
        checks++;
        if (rdata !== 32'h0000_FF00) begin errors++; $display("FAIL strobe_read: got %h want 0000ff00", rdata); end
    endtask

    task automatic test_irq_latency();
        gpio_in = '0;
        bus(A_REN, 32'h1, 4'hF);
        bus(A_FEN, 32'h0, 4'hF);
        repeat (4) step();
        bus(A_STS, 32'hFFFF, 4'hF);
        step();
        gpio_in = 16'h0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (irq !== (c >= 3)) begin errors++; $display("FAIL irq_latency_c%0d: got %b want %b", c, irq, c >= 3); end
        end
        bus(A_STS, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", irq); end
    endtask

    task automatic test_set_wins();
        bus(A_REN, 32'h0, 4'hF);
        bus(A_FEN, 32'h4, 4'hF);
        gpio_in = 16'h0004;
        repeat (4) step();
        bus(A_STS, 32'hFFFF, 4'hF);
        step();
        gpio_in = 16'h0000;
        step(); step();
        valid = 1'b1; addr = A_STS; wdata = 32'h4; wstrb = 4'hF;
        step();
        valid = 1'b0; wstrb = 4'h0;
        checks++;
        if (ready !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL set_wins: got ready=%b irq=%b want 1 1", ready, irq);
        end
        bus(A_FEN, 32'h0, 4'hF);
        bus(A_STS, 32'h0, 4'h0);
        checks++;
        if (irq !== 1'b1 || rdata !== 32'h4) begin
            errors++; $display("FAIL en_clear_keeps_status: got irq=%b rdata=%h want 1 00000004", irq, rdata);
        end
        bus(A_STS, 32'h4, 4'hF);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL status_clear: got %b want 0", irq); end
    endtask

    task automatic test_random();
        logic [7:0] offs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                  8'h18, 8'h1C, 8'h20, 8'h24, 8'hFC, 8'h02};
        logic [3:0] s;
        for (int n = 0; n < 120; n++) begin
            gpio_in = W'($urandom);
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            bus(BASE | 32'(offs[$urandom_range(0, 11)]), $urandom, s);
            repeat ($urandom_range(0, 2)) step();
            checks++;
            if ({ready, rdata, gpio_out, gpio_oe, irq} !== {m_ready, m_rdata, m_out, m_oe, |m_status}) begin
                errors++;
                $display("FAIL random_%0d: got %b %h %h %h %b want %b %h %h %h %b", n, ready, rdata,
                         gpio_out, gpio_oe, irq, m_ready, m_rdata, m_out, m_oe, |m_status);
            end
        end
        gpio_in = '0;
        bus(A_REN, 32'h0, 4'hF);
        bus(A_FEN, 32'h0, 4'hF);
    endtask

    task automatic test_back_to_back();
        logic prev;
        logic [W-1:0] keep;
        if (m_ready) step();
        valid = 1'b1; addr = A_TGL; wdata = 32'h1; wstrb = 4'hF;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (ready !== (k % 2 == 0) || (prev && ready)) begin
                errors++; $display("FAIL b2b_ready_%0d: got %b want %b", k, ready, k % 2 == 0);
            end
            prev = ready;
        end
        checks++;
        if (gpio_out !== m_out) begin errors++; $display("FAIL b2b_once: got %h want %h", gpio_out, m_out); end
        keep = gpio_out;
        addr = BASE + 32'h100; wdata = 32'hFFFF; wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ready !== 1'b0 || gpio_out !== keep) begin
                errors++; $display("FAIL miss_%0d: got ready=%b out=%h want 0 %h", k, ready, gpio_out, keep);
            end
        end
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic test_reset_mid();
        bus(A_OUT, 32'h5A5A, 4'hF);
        step();
        valid = 1'b1; addr = A_OUT; wdata = 32'h1234; wstrb = 4'hF; resetn = 1'b0;
        step();
        resetn = 1'b1; valid = 1'b0; wstrb = 4'h0;
        step();
        checks++;
        if (ready !== 1'b0 || rdata !== 32'h0 || gpio_out !== 16'h0) begin
            errors++; $display("FAIL reset_mid: got ready=%b rdata=%h out=%h want 0 0 0", ready, rdata, gpio_out);
        end
    endtask

    initial begin
        resetn = 1'b0; valid = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0; gpio_in = '0;
        test_reset();
        test_basic();
        test_set_clr_tgl();
        test_strobe();
        test_irq_latency();
        test_set_wins();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/picosoc_gpio.md
PICOSOC_GPIO -- requirements
Module: picosoc_gpio

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins (1..32).
REQ-002 Parameter BASE_ADDR, default 32'h0300_0000, block base; decode is addr[31:8] == BASE_ADDR[31:8].
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 valid  input  1  bus request, held by the master until ready.
REQ-007 ready  output  1  single-cycle acknowledge.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  write data.
REQ-010 wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-011 rdata  output  32  read data, valid while ready=1.
REQ-012 gpio_in  input  WIDTH  asynchronous pin inputs.
REQ-013 gpio_out  output  WIDTH  pin output values.
REQ-014 gpio_oe  output  WIDTH  per-pin output enable; 1 = drive.
REQ-015 irq  output  1  level interrupt, high while any status bit is set.

Function
REQ-016 Register map (offset, access):
- 0x00 OUT (RW)
- 0x04 OE (RW)
- 0x08 IN (RO, synchronised value)
- 0x0C SET (WO, OUT |= d)
- 0x10 CLR (WO, OUT &= ~d)
- 0x14 TGL (WO, OUT ^= d)
- 0x18 RISE_EN (RW)
- 0x1C FALL_EN (RW)
- 0x20 STATUS (W1C)
REQ-017 Reads of WO registers, unmapped offsets inside the 256-byte window, and bits [31:WIDTH] SHALL return 0; writes to them SHALL be ignored.
REQ-018 Handshake: ready SHALL be registered as valid && hit && !ready, so it pulses 1 cycle after valid and never on two consecutive cycles.
REQ-019 rdata SHALL be registered on the same edge as ready, SHALL be 0 when ready=0, and SHALL reflect register contents before that access's write.
REQ-020 A write SHALL take effect on the edge that asserts ready, exactly once per access.
REQ-021 Byte-enable rule: data bit i participates only if wstrb[i/8]=1, for every writable register including SET/CLR/TGL/STATUS.
REQ-022 When valid=0 or the address misses, ready SHALL stay 0 and no state SHALL change.
REQ-023 gpio_out and gpio_oe SHALL be driven directly from the OUT and OE registers, with no extra latency.
REQ-024 gpio_in SHALL pass through a SYNC_STAGES flop chain; IN reads the last stage.
REQ-025 Edge detection compares the last sync stage with a one-cycle-delayed copy:
- rise = s & ~p
- fall = ~s & p
REQ-026 STATUS[i] SHALL set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
REQ-027 If a W1C clear and a new event hit the same bit on the same cycle, set SHALL win.
REQ-028 irq SHALL equal |STATUS, combinational from the register.
REQ-029 Clearing an enable bit SHALL NOT clear the corresponding STATUS bit.
REQ-030 Pin-to-STATUS latency SHALL be SYNC_STAGES+1 cycles from the gpio_in transition; pin-to-irq latency is the same.

Reset
REQ-031 When resetn=0 at a clock edge, these SHALL become 0: OUT, OE, RISE_EN, FALL_EN, STATUS, the sync chain, the delayed copy, ready and rdata.
REQ-032 Reset asserted mid-access SHALL abort it: ready=0 next cycle, no register modified.
REQ-033 Because enables reset to 0, pins already high at reset release SHALL NOT set STATUS.

Verification
REQ-034 Reset, then write OUT=0xA5, OE=0xFF (wstrb=4'hF) -> gpio_out=0xA5, gpio_oe=0xFF; read OUT returns 0xA5 one cycle after valid.
REQ-035 Starting from OUT=0xA5: SET 0x0A -> 0xAF; CLR 0x81 -> 0x2E; TGL 0xFF -> 0xD1; any read of offset 0x0C returns 0.
REQ-036 WIDTH=16, OUT=0x0000, write 0xFFFF to SET with wstrb=4'b0010 -> OUT=0xFF00; read returns 0x0000FF00.
REQ-037 RISE_EN=0x01; gpio_in[0] goes 0->1 -> STATUS=0x01 and irq=1 exactly 3 cycles later (SYNC_STAGES=2); write STATUS=0x01 -> irq=0.
REQ-038 Timing: fall event on bit 2 (FALL_EN=0x04) lands on the same edge as a W1C of 0x04 -> STATUS[2] stays 1.
REQ-039 Back-to-back: valid held across two accesses -> ready never high on consecutive cycles; access to BASE_ADDR+0x100 -> ready stays 0.
